keccak_round_ctrl: RTL and testbench
====================================

// Module: keccak_round_ctrl
// PURPOSE
//  Sequencer for the Keccak-f state permutation datapath. On a start request it
//  runs ROUNDS rounds. Each round is the step sequence THETA, RHO, PI, CHI, IOTA.
//  Steps THETA..CHI sweep all 25 lanes (i,j in 0..4), one lane per cycle.
//  For each lane it emits the lane indices, the column neighbours (i+1, i+2, i+4
//  mod 5) and a write strobe for the state memory.
// PARAMETERS
//  ROUNDS   24   permutation rounds per start (1..31)
// PORTS
//  clk       in   1  clock, rising edge
//  rst_n     in   1  asynchronous active-low reset
//  start     in   1  begin permutation; sampled only in IDLE
//  stall     in   1  freeze sequencing this cycle (datapath/memory not ready)
//  ready     out  1  1 in IDLE
//  busy      out  1  1 in THETA..IOTA
//  done      out  1  one-cycle pulse when the last IOTA completes
//  step      out  3  0 IDLE,1 THETA,2 RHO,3 PI,4 CHI,5 IOTA,6 DONE
//  round     out  5  current round index, 0..ROUNDS-1
//  lane_i    out  3  current lane column, 0..4
//  lane_j    out  3  current lane row, 0..4
//  i_p1      out  3  (lane_i+1) mod 5
//  i_p2      out  3  (lane_i+2) mod 5: 0->2, 1->3, 2->4, 3->0, 4->1
//  i_m1      out  3  (lane_i+4) mod 5
//  wr_en     out  1  commit the datapath result for the current lane/step
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; step=0, round=0, lane_i=lane_j=0.
//   - busy=0, done=0, wr_en=0, ready=1.
//   - Neighbour outputs follow lane_i=0: i_p1=1, i_p2=2, i_m1=4.
//  Mid-operation reset aborts immediately; no done pulse is produced.
//  IDLE:
//   - start=1 at edge E -> THETA, round=0, i=j=0.
//   - start=0 -> stay in IDLE.
//  THETA/RHO/PI/CHI, stall=0:
//   - wr_en=1; lane_i increments each cycle.
//   - lane_i 4->0 increments lane_j.
//   - At (i,j)=(4,4), advance to the next step with i=j=0. CHI advances to IOTA.
//  IOTA:
//   - One cycle at lane (0,0) with wr_en=1.
//   - If round==ROUNDS-1 -> DONE; else round+1 -> THETA.
//  DONE:
//   - One cycle: done=1, busy=0, wr_en=0.
//   - Then IDLE (ready=1 on the next cycle).
//  stall=1 (any busy state):
//   - state, round, lane_i and lane_j all hold; wr_en=0.
//   - Outputs keep presenting the same lane.
//   - In IDLE, stall does not block start acceptance.
//  start while busy/DONE: ignored; not queued.
//  Neighbour outputs are combinational from lane_i and valid in every state.
//  Latency:
//   - Each round is 4*25+1 = 101 active cycles.
//   - done is visible after edge E + ROUNDS*101 + (number of stalled cycles).
//   - ROUNDS=24, no stalls: done at E+2424.
//  wr_en is asserted exactly 101*ROUNDS times per permutation.
//  Never write: lane index 5..7, round >= ROUNDS, or done and busy together.
// TESTING
//  1. Reset release, start=0 for 10 cycles -> ready=1, step=0, wr_en=0, done=0.
//  2. ROUNDS=24, start one cycle, no stall:
//     - done pulse exactly 2424 edges after acceptance.
//     - wr_en count = 2424; ready=1 the following cycle.
//  3. Lane order in step THETA of round 0:
//     - (i,j) sequence (0,0),(1,0)..(4,0),(0,1)..(4,4).
//     - i_p2 shows 2,3,4,0,1 across each row.
//     - Cycle 26 after acceptance shows step=2 (RHO) at (0,0).
//  4. stall=1 for 3 cycles at CHI lane (2,3):
//     - Lane, step and round are frozen; wr_en=0.
//     - Resumes at (2,3); done is delayed by exactly 3 cycles.
//  5. Hold start=1 continuously:
//     - Second permutation is accepted only from IDLE, one cycle after done.
//     - start pulses during busy have no effect.
//  6. rst_n=0 mid-round (round 7, PI) -> immediate IDLE, outputs at reset values,
//     no done pulse; a fresh start afterwards runs a full 2424-cycle permutation.

Source files
------------

// File: rtl/keccak_round_ctrl_if.sv
// Handshake/status bundle between the Keccak round sequencer and its user.
//   start, stall            : requests from the user (master) to the sequencer
//   ready, busy, done, step : sequencer status
//   round, lane_i, lane_j   : current round and lane coordinates
//   i_p1, i_p2, i_m1        : column neighbours of lane_i, modulo 5
//   wr_en                   : state-memory write strobe for the current lane/step
interface keccak_round_ctrl_if;
   logic       start;
   logic       stall;
   logic       ready;
   logic       busy;
   logic       done;
   logic [2:0] step;
   logic [4:0] round;
   logic [2:0] lane_i;
   logic [2:0] lane_j;
   logic [2:0] i_p1;
   logic [2:0] i_p2;
   logic [2:0] i_m1;
   logic       wr_en;

   modport master (
      output start, stall,
      input  ready, busy, done, step, round, lane_i, lane_j,
             i_p1, i_p2, i_m1, wr_en
   );

   modport slave (
      input  start, stall,
      output ready, busy, done, step, round, lane_i, lane_j,
             i_p1, i_p2, i_m1, wr_en
   );
endinterface

// File: rtl/keccak_round_ctrl.sv
// Sequencer for the Keccak-f permutation datapath.
// Runs ROUNDS rounds per start; each round sweeps the 25 lanes once for each
// of THETA, RHO, PI and CHI (one lane per cycle, i fastest), then spends one
// cycle in IOTA at lane (0,0). A stall freezes everything and drops wr_en.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : keccak_round_ctrl_if slave (start/stall in, status/lanes out)
// Parameter:
//   ROUNDS     : permutation rounds per start, 1..31
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE  0 | waiting for start, ready=1
// THETA 1 | lane sweep, theta step
// RHO   2 | lane sweep, rho step
// PI    3 | lane sweep, pi step
// CHI   4 | lane sweep, chi step
// IOTA  5 | single cycle at lane (0,0), then next round or DONE
// DONE  6 | one-cycle done pulse, then IDLE
module keccak_round_ctrl #(
   parameter int ROUNDS = 24
) (
   input logic                clk,
   input logic                rst_n,
   keccak_round_ctrl_if.slave bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_THETA = 3'd1;
   localparam logic [2:0] S_RHO   = 3'd2;
   localparam logic [2:0] S_PI    = 3'd3;
   localparam logic [2:0] S_CHI   = 3'd4;
   localparam logic [2:0] S_IOTA  = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

   logic [2:0] state;
   logic [4:0] round;
   logic [2:0] lane_i;
   logic [2:0] lane_j;
   logic       busy;

   assign busy = (state >= S_THETA) && (state <= S_IOTA);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         round  <= 5'd0;
         lane_i <= 3'd0;
         lane_j <= 3'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state  <= S_THETA;
                  round  <= 5'd0;
                  lane_i <= 3'd0;
                  lane_j <= 3'd0;
               end
            end
            S_THETA, S_RHO, S_PI, S_CHI: begin
               if (!bus.stall) begin
                  if (lane_i == 3'd4) begin
                     lane_i <= 3'd0;
                     if (lane_j == 3'd4) begin
                        lane_j <= 3'd0;
                        // sweep steps are numbered consecutively; CHI+1 is IOTA
                        state  <= state + 3'd1;
                     end else begin
                        lane_j <= lane_j + 3'd1;
                     end
                  end else begin
                     lane_i <= lane_i + 3'd1;
                  end
               end
            end
            S_IOTA: begin
               if (!bus.stall) begin
                  if (round == LAST_ROUND) begin
                     state <= S_DONE;
                  end else begin
                     round <= round + 5'd1;
                     state <= S_THETA;
                  end
               end
            end
            S_DONE: begin
               // round stays at its last value during the done pulse,
               // and returns to 0 for the idle presentation
               state <= S_IDLE;
               round <= 5'd0;
            end
            default: begin
               state  <= S_IDLE;
               round  <= 5'd0;
               lane_i <= 3'd0;
               lane_j <= 3'd0;
            end
         endcase
      end
   end

   // Column neighbours, mod 5, from the presented lane
   always_comb begin
      bus.i_p1 = 3'd1;
      bus.i_p2 = 3'd2;
      bus.i_m1 = 3'd4;
      case (lane_i)
         3'd0: begin bus.i_p1 = 3'd1; bus.i_p2 = 3'd2; bus.i_m1 = 3'd4; end
         3'd1: begin bus.i_p1 = 3'd2; bus.i_p2 = 3'd3; bus.i_m1 = 3'd0; end
         3'd2: begin bus.i_p1 = 3'd3; bus.i_p2 = 3'd4; bus.i_m1 = 3'd1; end
         3'd3: begin bus.i_p1 = 3'd4; bus.i_p2 = 3'd0; bus.i_m1 = 3'd2; end
         3'd4: begin bus.i_p1 = 3'd0; bus.i_p2 = 3'd1; bus.i_m1 = 3'd3; end
         default: begin bus.i_p1 = 3'd1; bus.i_p2 = 3'd2; bus.i_m1 = 3'd4; end
      endcase
   end

   assign bus.ready  = (state == S_IDLE);
   assign bus.busy   = busy;
   assign bus.done   = (state == S_DONE);
   assign bus.step   = state;
   assign bus.round  = round;
   assign bus.lane_i = lane_i;
   assign bus.lane_j = lane_j;
   assign bus.wr_en  = busy && !bus.stall;

endmodule

// File: tb/tb_keccak_round_ctrl.sv
module tb_keccak_round_ctrl;

   localparam int ROUNDS = 24;
   localparam int PERM   = ROUNDS * 101;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   keccak_round_ctrl_if bus ();

   keccak_round_ctrl #(.ROUNDS(ROUNDS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // reference model: mode 0 idle, 1 running, 2 done; pos = active cycles consumed
   int m_mode = 0;
   int m_pos  = 0;
   int edges  = 0;
   int acc_edge  = 0;
   int done_edge = 0;
   int done_seen = 0;
   int dut_wr    = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] pack(input int rdy, input int bsy, input int dn, input int st,
                                        input int rnd, input int i, input int j, input int wr);
      logic [31:0] v;
      v = {5'd0, 1'(rdy), 1'(bsy), 1'(dn), 3'(st), 5'(rnd), 3'(i), 3'(j),
           3'((i + 1) % 5), 3'((i + 2) % 5), 3'((i + 4) % 5), 1'(wr)};
      return v;
   endfunction

   function automatic logic [31:0] exp_outs(input logic st_in);
      int r, l;
      if (m_mode == 0) return pack(1, 0, 0, 0, 0, 0, 0, 0);
      if (m_mode == 2) return pack(0, 0, 1, 6, ROUNDS - 1, 0, 0, 0);
      r = m_pos % 101;
      l = (r < 100) ? r % 25 : 0;
      return pack(0, 1, 0, (r < 100) ? 1 + r / 25 : 5, m_pos / 101, l % 5, l / 5, st_in ? 0 : 1);
   endfunction

   function automatic logic [31:0] obs_outs();
      return {5'd0, bus.ready, bus.busy, bus.done, bus.step, bus.round, bus.lane_i, bus.lane_j,
              bus.i_p1, bus.i_p2, bus.i_m1, bus.wr_en};
   endfunction

   // one clock: drive at negedge, check, then advance the model on the edge
   task automatic cycle(input logic s, input logic st);
      bus.start = s;
      bus.stall = st;
      #1;
      check_val("outs", obs_outs(), exp_outs(st));
      if (bus.wr_en === 1'b1) dut_wr++;
      if (bus.done === 1'b1) begin
         done_seen++;
         done_edge = edges;
      end
      @(posedge clk);
      edges++;
      if (!rst_n) begin
         m_mode = 0;
         m_pos  = 0;
      end else begin
         case (m_mode)
            0: if (s) begin m_mode = 1; m_pos = 0; acc_edge = edges; end
            1: if (!st) begin m_pos++; if (m_pos == PERM) m_mode = 2; end
            default: m_mode = 0;
         endcase
      end
      @(negedge clk);
   endtask

   // start_mode: 0 start low after acceptance, 1 held high, 2 random
   task automatic run_perm(input int stall_pct, input int start_mode, input bit chi_stall);
      int   n_stall, chi_cnt, n;
      logic s, st;
      n_stall   = 0;
      chi_cnt   = 0;
      dut_wr    = 0;
      done_seen = 0;
      n         = 0;
      while (done_seen == 0 && n < PERM + 2000) begin
         if (n == 0) s = 1'b1;
         else if (start_mode == 1) s = 1'b1;
         else if (start_mode == 2) s = 1'($urandom_range(1));
         else s = 1'b0;
         st = ($urandom_range(99) < stall_pct) ? 1'b1 : 1'b0;
         if (chi_stall && m_mode == 1 && m_pos == 75 + 17 && chi_cnt < 3) begin
            st = 1'b1;
            chi_cnt++;
         end
         if (st && m_mode == 1) n_stall++;
         cycle(s, st);
         n++;
      end
      check_val("done_timeout", 32'(done_seen), 32'd1);
      check_val("latency", 32'(done_edge - acc_edge), 32'(PERM + n_stall));
      check_val("wr_count", 32'(dut_wr), 32'(PERM));
      check_val("ready_after", 32'(bus.ready), 32'd1);
      if (chi_stall) check_val("chi_stalls", 32'(chi_cnt), 32'd3);
   endtask

   initial begin
      int n;
      bus.start = 1'b0;
      bus.stall = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_val("reset_outs", obs_outs(), pack(1, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      #2 rst_n = 1'b1;
      for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0);

      // plain permutation
      run_perm(0, 0, 1'b0);
      cycle(1'b0, 1'b0);
      // stall 3 cycles at CHI lane (2,3) of round 0
      run_perm(0, 0, 1'b1);
      cycle(1'b0, 1'b0);
      // start held high: back-to-back permutations, each from IDLE
      run_perm(0, 1, 1'b0);
      run_perm(0, 1, 1'b0);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);

      // reset mid-run at round 7, PI
      done_seen = 0;
      cycle(1'b1, 1'b0);
      n = 0;
      while (!(m_mode == 1 && m_pos / 101 == 7 && (m_pos % 101) / 25 == 2 && (m_pos % 101) < 100)
             && n < 2000) begin
         cycle(1'($urandom_range(1)), 1'b0);
         n++;
      end
      check_val("reach_r7_pi", 32'(bus.step), 32'd3);
      #2 rst_n = 1'b0;
      m_mode = 0;
      m_pos  = 0;
      #1;
      check_val("midrst_outs", obs_outs(), pack(1, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0);
      #2 rst_n = 1'b1;
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0);
      check_val("no_done_after_rst", 32'(done_seen), 32'd0);
      run_perm(0, 0, 1'b0);
      cycle(1'b0, 1'b0);

      // random stalls and random start pulses while busy
      run_perm(25, 2, 1'b0);
      for (int k = 0; k < 5; k++) cycle(1'b0, 1'($urandom_range(1)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
